// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS_N/MOSI on i_clk, deserialises MOSI into
// words with a one-cycle valid strobe and serialises a handshaked tx word on MISO.
module spi_slave #(
  parameter int unsigned          SPI_MODE  = 0,
  parameter int unsigned          DATAWIDTH = 8,
  parameter logic [DATAWIDTH-1:0] TX_IDLE   = '1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_spi_clk,
  input  logic                 i_spi_cs_n,
  input  logic                 i_spi_MOSI,
  output logic                 o_spi_MISO,
  output logic                 o_spi_MISO_en,
  input  logic [DATAWIDTH-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_rx_valid,
  output logic [DATAWIDTH-1:0] o_rx_data
);

  localparam bit CPOL = ((SPI_MODE / 2) % 2) == 1;
  localparam bit CPHA = (SPI_MODE % 2) == 1;
  localparam int unsigned CNT_W = $clog2(DATAWIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATAWIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATAWIDTH - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Synchroniser chains; the *_prev flops provide edge detection.
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, as real hardware does.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sclk_meta_q <= CPOL;
      sclk_sync_q <= CPOL;
      sclk_prev_q <= CPOL;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= i_spi_clk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= i_spi_cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= i_spi_MOSI;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;

  assign lead_edge   = (sclk_sync_q != CPOL) && (sclk_prev_q == CPOL);
  assign trail_edge  = (sclk_sync_q == CPOL) && (sclk_prev_q != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev_q && !cs_sync_q;

  logic [0:0]           state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATAWIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATAWIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATAWIDTH-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATAWIDTH-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 miso_q, miso_d;
  logic                 miso_en_q, miso_en_d;

  logic                 frame_start;
  logic                 go_idle;
  logic [DATAWIDTH-1:0] next_word;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    miso_en_d   = miso_en_q;
    frame_start = 1'b0;
    go_idle     = 1'b0;
    next_word   = TX_IDLE;

    // Load and transfer are exclusive: one needs the register empty, the other full.
    if (i_tx_valid && !hold_full_q) begin
      hold_d      = i_tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) frame_start = 1'b1;
      end
      ST_ACTIVE: begin
        if (bit_cnt_q == FULL_CNT) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          bit_cnt_d  = '0;
          if (!cs_sync_q) frame_start = 1'b1;
          else            go_idle     = 1'b1;
        end else if (cs_sync_q) begin
          // A final sample edge coincident with deselect still completes the word.
          if (sample_edge && (bit_cnt_q == LAST_CNT)) begin
            rx_shift_d = {rx_shift_q[DATAWIDTH-2:0], mosi_sync_q};
            bit_cnt_d  = FULL_CNT;
          end else begin
            go_idle = 1'b1;
          end
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATAWIDTH-2:0], mosi_sync_q};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
          // In CPHA=0 the trailing edge after the last bit lands in the next
          // frame with the counter at zero; it must not disturb the new MSB.
          if (shift_edge && (CPHA || (bit_cnt_q != '0))) begin
            miso_d     = tx_shift_q[DATAWIDTH-1];
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (frame_start) begin
      if (hold_full_q) begin
        next_word   = hold_q;
        hold_full_d = 1'b0;
      end
      if (CPHA) begin
        tx_shift_d = next_word;
      end else begin
        miso_d     = next_word[DATAWIDTH-1];
        tx_shift_d = next_word << 1;
      end
      miso_en_d = 1'b1;
      bit_cnt_d = '0;
      state_d   = ST_ACTIVE;
    end

    if (go_idle) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      miso_en_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      miso_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      miso_en_q   <= miso_en_d;
    end
  end

  assign o_spi_MISO    = miso_q;
  assign o_spi_MISO_en = miso_en_q;
  assign o_tx_ready    = !hold_full_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_rx_data     = rx_data_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode, the bench acts as
// the SPI master with a half-bit of 4 system clocks.
module tb_spi_slave;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sclk, cs_n, miso, miso_en, tx_valid, tx_ready, rx_valid;
  logic       mosi;
  logic [7:0] tx_data [4];
  logic [7:0] rx_data [4];

  int tests  = 0;
  int failed = 0;

  int         rx_pulses [4] = '{0, 0, 0, 0};
  logic [7:0] rx_hist [4][16];
  logic [3:0] rx_valid_prev = 4'b0;
  int         long_pulses = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave #(.SPI_MODE(m), .DATAWIDTH(8)) u_dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_spi_clk     (sclk[m]),
      .i_spi_cs_n    (cs_n[m]),
      .i_spi_MOSI    (mosi),
      .o_spi_MISO    (miso[m]),
      .o_spi_MISO_en (miso_en[m]),
      .i_tx_data     (tx_data[m]),
      .i_tx_valid    (tx_valid[m]),
      .o_tx_ready    (tx_ready[m]),
      .o_rx_valid    (rx_valid[m]),
      .o_rx_data     (rx_data[m])
    );
  end

  // Receive monitor: logs every strobe and flags strobes longer than one cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i]) begin
        rx_hist[i][rx_pulses[i] % 16] = rx_data[i];
        rx_pulses[i] = rx_pulses[i] + 1;
        if (rx_valid_prev[i]) long_pulses = long_pulses + 1;
      end
    end
    rx_valid_prev = rx_valid;
  end

  task automatic load_tx(input int m, input logic [7:0] d);
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic cs_low(input int m);
    @(negedge clk);
    cs_n[m] = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic cs_high(input int m);
    cs_n[m] = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[0];
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      if (!cpha) rx[7-i] = miso[m];
      sclk[m] = ~cpol;
      if (cpha) mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      if (cpha) rx[7-i] = miso[m];
      sclk[m] = cpol;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      tests++;
      if ({miso[m], miso_en[m], tx_ready[m], rx_valid[m], rx_data[m]} !== 12'b0010_0000_0000) begin
        failed++;
        $display("FAIL reset_state[%0d]: miso=%b en=%b ready=%b valid=%b data=%h, want 0 0 1 0 00",
                 m, miso[m], miso_en[m], tx_ready[m], rx_valid[m], rx_data[m]);
      end
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mode0_basic;
    logic [7:0] r;
    int p;
    p = rx_pulses[0];
    load_tx(0, 8'h5C);
    tests++;
    if (tx_ready[0] !== 1'b0) begin
      failed++; $display("FAIL basic_ready_drop: got %b want 0", tx_ready[0]);
    end
    load_tx(0, 8'h11);
    cs_low(0);
    tests++;
    if ({miso_en[0], tx_ready[0]} !== 2'b11) begin
      failed++; $display("FAIL basic_frame_start: en,ready=%b%b want 11", miso_en[0], tx_ready[0]);
    end
    xfer(0, 8'hAB, 8, r);
    cs_high(0);
    tests++;
    if (r !== 8'h5C) begin
      failed++; $display("FAIL basic_master_rx: got %h want 5c", r);
    end
    tests++;
    if ((rx_pulses[0] - p) !== 1 || rx_data[0] !== 8'hAB) begin
      failed++; $display("FAIL basic_slave_rx: pulses=%0d data=%h want 1 ab", rx_pulses[0] - p, rx_data[0]);
    end
    tests++;
    if (miso_en[0] !== 1'b0) begin
      failed++; $display("FAIL basic_deselect_en: got %b want 0", miso_en[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r1, r2;
    int p;
    p = rx_pulses[0];
    load_tx(0, 8'hC3);
    cs_low(0);
    fork
      xfer(0, 8'h12, 8, r1);
      begin
        repeat (6 * HALF) @(negedge clk);
        load_tx(0, 8'h3C);
      end
    join
    xfer(0, 8'h34, 8, r2);
    cs_high(0);
    tests++;
    if (r1 !== 8'hC3 || r2 !== 8'h3C) begin
      failed++; $display("FAIL b2b_master_rx: got %h %h want c3 3c", r1, r2);
    end
    tests++;
    if ((rx_pulses[0] - p) !== 2 || rx_hist[0][p % 16] !== 8'h12 || rx_hist[0][(p + 1) % 16] !== 8'h34) begin
      failed++; $display("FAIL b2b_slave_rx: pulses=%0d words=%h %h want 2 12 34",
                         rx_pulses[0] - p, rx_hist[0][p % 16], rx_hist[0][(p + 1) % 16]);
    end
  endtask

  task automatic test_abort;
    logic [7:0] r;
    int p;
    p = rx_pulses[0];
    cs_low(0);
    xfer(0, 8'hF0, 4, r);
    cs_high(0);
    tests++;
    if ((rx_pulses[0] - p) !== 0 || rx_data[0] !== 8'h34) begin
      failed++; $display("FAIL abort_discard: pulses=%0d data=%h want 0 34", rx_pulses[0] - p, rx_data[0]);
    end
    cs_low(0);
    xfer(0, 8'h81, 8, r);
    cs_high(0);
    tests++;
    if ((rx_pulses[0] - p) !== 1 || rx_data[0] !== 8'h81 || r !== 8'hFF) begin
      failed++; $display("FAIL abort_next_frame: pulses=%0d data=%h master=%h want 1 81 ff",
                         rx_pulses[0] - p, rx_data[0], r);
    end
  endtask

  task automatic test_no_tx_word;
    logic [7:0] r;
    int p;
    p = rx_pulses[0];
    cs_low(0);
    xfer(0, 8'h00, 8, r);
    cs_high(0);
    tests++;
    if (r !== 8'hFF) begin
      failed++; $display("FAIL idle_word: got %h want ff", r);
    end
    tests++;
    if ((rx_pulses[0] - p) !== 1 || rx_data[0] !== 8'h00) begin
      failed++; $display("FAIL idle_slave_rx: pulses=%0d data=%h want 1 00", rx_pulses[0] - p, rx_data[0]);
    end
  endtask

  task automatic test_modes;
    logic [7:0] r;
    int p;
    for (int m = 1; m < 4; m++) begin
      p = rx_pulses[m];
      load_tx(m, 8'h96);
      cs_low(m);
      xfer(m, 8'hA5, 8, r);
      cs_high(m);
      tests++;
      if (r !== 8'h96) begin
        failed++; $display("FAIL mode%0d_master_rx: got %h want 96", m, r);
      end
      tests++;
      if ((rx_pulses[m] - p) !== 1 || rx_data[m] !== 8'hA5) begin
        failed++; $display("FAIL mode%0d_slave_rx: pulses=%0d data=%h want 1 a5", m, rx_pulses[m] - p, rx_data[m]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] r;
    int p;
    p = rx_pulses[0];
    load_tx(0, 8'h5A);
    cs_low(0);
    load_tx(0, 8'h77);
    tests++;
    if (tx_ready[0] !== 1'b0) begin
      failed++; $display("FAIL rstmid_hold_full: ready=%b want 0", tx_ready[0]);
    end
    xfer(0, 8'hE0, 3, r);
    rst = 1'b1;
    #1;
    tests++;
    if ({miso[0], miso_en[0], tx_ready[0], rx_valid[0], rx_data[0]} !== 12'b0010_0000_0000) begin
      failed++;
      $display("FAIL rstmid_outputs: miso=%b en=%b ready=%b valid=%b data=%h, want 0 0 1 0 00",
               miso[0], miso_en[0], tx_ready[0], rx_valid[0], rx_data[0]);
    end
    @(negedge clk);
    cs_n[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    cs_low(0);
    xfer(0, 8'h7E, 8, r);
    cs_high(0);
    tests++;
    if ((rx_pulses[0] - p) !== 1 || rx_data[0] !== 8'h7E) begin
      failed++; $display("FAIL rstmid_next_frame: pulses=%0d data=%h want 1 7e", rx_pulses[0] - p, rx_data[0]);
    end
    tests++;
    if (r !== 8'hFF) begin
      failed++; $display("FAIL rstmid_hold_cleared: master got %h want ff", r);
    end
  endtask

  task automatic test_pulse_width;
    tests++;
    if (long_pulses !== 0) begin
      failed++; $display("FAIL rx_valid_width: %0d multi-cycle strobes, want 0", long_pulses);
    end
  endtask

  initial begin
    rst      = 1'b1;
    sclk     = 4'b1100;
    cs_n     = 4'hF;
    mosi     = 1'b0;
    tx_valid = 4'h0;
    for (int m = 0; m < 4; m++) tx_data[m] = 8'h00;

    test_reset();
    test_mode0_basic();
    test_back_to_back();
    test_abort();
    test_no_tx_word();
    test_modes();
    test_reset_mid_frame();
    test_pulse_width();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral (responder) end of the link driven by spiMaster; lives in the SoC peripheral side, e.g. for loopback and peripheral emulation.
- Oversamples the external SPI signals on the system clock.
- Deserialises MOSI into parallel words with a valid strobe.
- Serialises a pre-loaded parallel word onto MISO, using a ready/valid load handshake.

Parameters:
SPI_MODE  0  SPI mode 0-3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]; must match the master
DATAWIDTH  8  bits per frame, MSB first
TX_IDLE  all ones (DATAWIDTH bits)  word shifted out when no tx word is loaded

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_spi_clk  input  1  SPI clock from master (asynchronous to i_clk)
i_spi_cs_n  input  1  chip select, active low
i_spi_MOSI  input  1  master-out serial data
o_spi_MISO  output  1  slave-out serial data
o_spi_MISO_en  output  1  MISO output enable (1 while selected)
i_tx_data  input  DATAWIDTH  next word to transmit
i_tx_valid  input  1  i_tx_data valid
o_tx_ready  output  1  holding register empty
o_rx_valid  output  1  one-cycle strobe: o_rx_data holds a new word
o_rx_data  output  DATAWIDTH  last complete received word

Behaviour:
- Reset (async, i_reset=1):
  - o_spi_MISO=0, o_spi_MISO_en=0, o_tx_ready=1, o_rx_valid=0, o_rx_data=0.
  - Bit counter 0, holding register empty, state IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no rx_valid is produced.
- Input sync:
  - i_spi_clk, i_spi_cs_n and i_spi_MOSI each pass through 2 flops.
  - A third flop on the synced clock and on the synced cs_n gives edge detect.
  - All logic acts on synced signals; latency from pin to action is 2-3 i_clk cycles.
- Edges:
  - Leading edge = synced SCLK leaves CPOL level; trailing edge = returns to CPOL level.
  - CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.
- Timing constraint: master half-bit must be >= 4 i_clk cycles, so MISO settles before the master samples. Test with CLKS_PER_HALF_BIT=4.
- Tx handshake:
  - Load when i_tx_valid & o_tx_ready; o_tx_ready drops the next cycle.
  - Holding register transfers into the tx shift register at frame start. A frame starts at the cs_n falling edge, or at the cycle after the last sample edge of the previous frame while cs_n stays low.
  - o_tx_ready returns to 1 the cycle after the transfer.
  - If the holding register is empty at frame start, the shift register loads TX_IDLE.
  - i_tx_valid while o_tx_ready=0 is ignored; the holding register is not overwritten.
- States:
  - IDLE: cs_n high; MISO_en=0; MISO=0.
    - On cs_n fall -> ACTIVE: MISO_en=1, shift register loaded.
    - If CPHA=0, MISO = MSB immediately.
  - ACTIVE:
    - Sample edge: shift synced MOSI into rx shift register LSB, bit counter +1.
    - Shift edge: MISO = next bit. For CPHA=1 the first leading edge presents the MSB.
    - At counter = DATAWIDTH:
      - Next cycle: o_rx_data <= rx shift register, o_rx_valid=1 for exactly one cycle, counter wraps to 0.
      - New tx word loaded; for CPHA=0, MISO = its MSB.
      - Back-to-back frames need no cs_n toggle.
    - On cs_n rise -> IDLE: partial frame discarded (counter 0, no rx_valid, o_rx_data unchanged), MISO_en=0.
    - An unconsumed holding word is kept for the next selection.
- Simultaneous events:
  - cs_n rising in the same cycle as the final sample edge: the word completes and o_rx_valid fires, then IDLE.
  - Tx load in the same cycle as a frame-start transfer: the transfer uses the old holding content (or TX_IDLE); the new word is kept for the next frame.
- SCLK edges while cs_n is high are ignored.

Test Plan:
- Mode 0, master sends 0xAB, slave preloaded 0x5C -> one o_rx_valid pulse with o_rx_data=0xAB; master o_rx_data=0x5C; slave o_tx_ready=1 after frame start.
- Mode 0, two frames back-to-back with cs_n held low, master 0x12/0x34, slave preloads 0xC3 then loads 0x3C during frame 1 -> slave rx 0x12 then 0x34; master rx 0xC3 then 0x3C.
- No tx word loaded, master sends 0x00 -> master receives 0xFF; slave rx 0x00.
- Modes 1, 2, 3 each, master 0xA5 / slave 0x96 -> both sides receive the other's word intact.
- cs_n raised after 4 bits, then a full frame 0x81 -> no rx_valid for the aborted frame; next rx_valid gives 0x81.
- i_reset pulsed mid-frame after 3 bits -> all outputs at reset values; a following full frame 0x7E is received correctly.
